// File: rtl/nios_system_pio_gen.sv
// -----------------------------------------------------------------------------
// nios_system_pio_gen
// Parametrised Avalon-MM GPIO block: DATA_WIDTH bidirectional bits with
// per-bit direction, synchronised inputs feeding sticky write-1-to-clear
// edge-capture bits, a maskable level interrupt, and atomic set/clear
// aliases for the output register.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (0 DATA, 1 DIRECTION, 2 IRQ_MASK,
//               3 EDGE_CAPTURE, 4 OUTSET, 5 OUTCLEAR, 6/7 reserved)
//   chipselect  slave select (writes only)
//   write_n     active-low write strobe
//   writedata   write data, low DATA_WIDTH bits used
//   readdata    combinational read data, zero-extended
//   in_port     asynchronous pad inputs
//   out_port    output data register
//   oe_port     direction register, 1 = drive pad
//   irq         |(edge_capture & irq_mask)
// -----------------------------------------------------------------------------
module nios_system_pio_gen #(
   parameter int unsigned            DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
   parameter int unsigned            EDGE_TYPE   = 0,
   parameter int unsigned            SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0] oe_port,
   output logic                  irq
);

   // Warm-up length: enough clocks for the synchroniser and prev flops to
   // hold real pad values before edges are trusted.
   localparam logic [2:0] WARM_CNT = 3'(SYNC_STAGES + 1);

   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] dir_q, dir_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] cap_q, cap_d;
   logic [2:0]            warm_q, warm_d;

   logic [DATA_WIDTH-1:0] sync;
   logic [DATA_WIDTH-1:0] edge_det;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] cap_clr;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  wr_en;
   logic                  warm_done;

   assign sync      = sync_q[SYNC_STAGES-1];
   assign wd        = writedata[DATA_WIDTH-1:0];
   assign wr_en     = chipselect & ~write_n;
   assign warm_done = (warm_q == WARM_CNT);

   generate
      if (DATA_WIDTH < 32) begin : g_unused_wd
         logic unused_wd_hi;
         assign unused_wd_hi = ^writedata[31:DATA_WIDTH];
      end
   endgenerate

   always_comb begin
      edge_det = '0;
      case (EDGE_TYPE)
         0:       edge_det = sync & ~prev_q;
         1:       edge_det = ~sync & prev_q;
         default: edge_det = sync ^ prev_q;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      dir_d   = dir_q;
      mask_d  = mask_q;
      cap_clr = '0;
      warm_d  = warm_done ? warm_q : warm_q + 3'd1;
      if (wr_en) begin
         case (address)
            3'd0: data_d  = wd;
            3'd1: dir_d   = wd;
            3'd2: mask_d  = wd;
            3'd3: cap_clr = wd;
            3'd4: data_d  = data_q | wd;
            3'd5: data_d  = data_q & ~wd;
            default: ;
         endcase
      end
      // A freshly detected edge overrides a simultaneous clear of that bit.
      cap_d = (cap_q & ~cap_clr) | (warm_done ? edge_det : '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
         prev_q <= '0;
         data_q <= RESET_VALUE;
         dir_q  <= '0;
         mask_q <= '0;
         cap_q  <= '0;
         warm_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync;
         data_q <= data_d;
         dir_q  <= dir_d;
         mask_q <= mask_d;
         cap_q  <= cap_d;
         warm_q <= warm_d;
      end
   end

   always_comb begin
      rd_val = '0;
      case (address)
         3'd0:    rd_val = sync;
         3'd1:    rd_val = dir_q;
         3'd2:    rd_val = mask_q;
         3'd3:    rd_val = cap_q;
         default: rd_val = '0;
      endcase
      readdata = 32'(rd_val);
   end

   assign out_port = data_q;
   assign oe_port  = dir_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_system_pio_gen.sv
module tb_nios_system_pio_gen;
   localparam int S  = 2;
   localparam int DW = 8;
   localparam logic [DW-1:0] RV = 8'hA5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect, write_n;
   logic [31:0]   writedata;
   logic [DW-1:0] in_port;
   logic [31:0]   rd   [3];
   logic [DW-1:0] outp [3];
   logic [DW-1:0] oep  [3];
   logic          irqv [3];

   int checks   = 0;
   int failures = 0;

   // index 0 = rising, 1 = falling, 2 = any
   nios_system_pio_gen #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(in_port),
      .out_port(outp[0]), .oe_port(oep[0]), .irq(irqv[0]));
   nios_system_pio_gen #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .EDGE_TYPE(1), .SYNC_STAGES(S)) dut_f (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(in_port),
      .out_port(outp[1]), .oe_port(oep[1]), .irq(irqv[1]));
   nios_system_pio_gen #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(in_port),
      .out_port(outp[2]), .oe_port(oep[2]), .irq(irqv[2]));

   // Reference model: keeps the history of pad samples taken at each clock
   // since reset release. Sample k is visible on reads after edge k+S-1, and
   // a change between samples j-1 and j is captured at edge j+S, provided
   // that edge is at least S+2 clocks after release.
   logic [DW-1:0] hist [$];
   int            ncyc;
   logic [DW-1:0] m_out, m_dir, m_mask, m_sync;
   logic [DW-1:0] m_cap [3];
   logic [DW-1:0] nv, ov, clr, st;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist.delete();
         ncyc   = 0;
         m_out  = RV;
         m_dir  = '0;
         m_mask = '0;
         m_sync = '0;
         for (int e = 0; e < 3; e++) m_cap[e] = '0;
      end else begin
         ncyc++;
         hist.push_back(in_port);
         clr = (chipselect && !write_n && address == 3'd3) ? writedata[DW-1:0] : '0;
         for (int e = 0; e < 3; e++) begin
            st = '0;
            if (ncyc >= S + 2) begin
               nv = hist[ncyc-S-1];
               ov = hist[ncyc-S-2];
               st = (e == 0) ? (nv & ~ov) : (e == 1) ? (~nv & ov) : (nv ^ ov);
            end
            m_cap[e] = (m_cap[e] & ~clr) | st;
         end
         if (chipselect && !write_n) begin
            case (address)
               3'd0: m_out  = writedata[DW-1:0];
               3'd1: m_dir  = writedata[DW-1:0];
               3'd2: m_mask = writedata[DW-1:0];
               3'd4: m_out  = m_out | writedata[DW-1:0];
               3'd5: m_out  = m_out & ~writedata[DW-1:0];
               default: ;
            endcase
         end
         m_sync = (ncyc - S >= 0) ? hist[ncyc-S] : '0;
      end
   end

   function automatic logic [31:0] exp_rd(int e, logic [2:0] a);
      case (a)
         3'd0:    return {24'h0, m_sync};
         3'd1:    return {24'h0, m_dir};
         3'd2:    return {24'h0, m_mask};
         3'd3:    return {24'h0, m_cap[e]};
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      tick();
      bus_idle();
   endtask

   task automatic apply_reset(input logic [DW-1:0] pads);
      reset_n = 1'b0;
      in_port = pads;
      bus_idle();
      address = 3'd0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      tick();
      reset_n = 1'b0;
      address = 3'd0;
      #1;
      for (int e = 0; e < 3; e++) begin
         checks++;
         if (outp[e] !== RV || oep[e] !== 8'h00 || irqv[e] !== 1'b0 || rd[e] !== 32'h0) begin
            failures++;
            $display("FAIL reset dut%0d: out=%h oe=%h irq=%b rd=%h required out=%h oe=00 irq=0 rd=0",
                     e, outp[e], oep[e], irqv[e], rd[e], RV);
         end
      end
      apply_reset(8'h00);
   endtask

   task automatic test_data_path();
      logic [7:0] exp_seq [5];
      logic [2:0] a_seq   [5];
      logic [7:0] d_seq   [5];
      exp_seq = '{8'h3C, 8'h3F, 8'h0F, 8'h0F, 8'h0F};
      a_seq   = '{3'd0, 3'd4, 3'd5, 3'd4, 3'd5};
      d_seq   = '{8'h3C, 8'h03, 8'h30, 8'h00, 8'h00};
      apply_reset(8'h00);
      for (int i = 0; i < 5; i++) begin
         bus_write(a_seq[i], {24'hFFFFFF, d_seq[i]});
         checks++;
         if (outp[0] !== exp_seq[i]) begin
            failures++;
            $display("FAIL data_path step%0d: out_port=%h required %h", i, outp[0], exp_seq[i]);
         end
      end
      bus_write(3'd1, 32'h5A);
      for (int a = 1; a <= 5; a += 3) begin
         address = 3'(a);
         #1;
         checks++;
         if (rd[0] !== ((a == 1) ? 32'h5A : 32'h0) || oep[0] !== 8'h5A) begin
            failures++;
            $display("FAIL data_path read a=%0d: rd=%h oe=%h", a, rd[0], oep[0]);
         end
      end
      address = 3'd5;
      #1;
      checks++;
      if (rd[0] !== 32'h0) begin
         failures++;
         $display("FAIL data_path read5: rd=%h required 0", rd[0]);
      end
   endtask

   task automatic test_warmup();
      apply_reset(8'hFF);
      for (int i = 0; i < 8; i++) begin
         tick();
         address = 3'd3;
         #1;
         checks++;
         if (rd[0] !== 32'h0 || rd[1] !== 32'h0 || rd[2] !== 32'h0) begin
            failures++;
            $display("FAIL warmup cyc%0d: cap=%h/%h/%h required 0", i, rd[0], rd[1], rd[2]);
         end
      end
      in_port = 8'hFE;
      repeat (S + 3) tick();
      bus_write(3'd3, 32'hFF);
      in_port = 8'hFF;
      repeat (S) tick();
      address = 3'd3;
      #1;
      checks++;
      if (rd[0] !== 32'h0) begin
         failures++;
         $display("FAIL warmup early: cap=%h required 0", rd[0]);
      end
      tick();
      address = 3'd3;
      #1;
      checks++;
      if (rd[0] !== 32'h1) begin
         failures++;
         $display("FAIL warmup rise: cap=%h required 1", rd[0]);
      end
   endtask

   task automatic test_irq();
      checks++;
      if (irqv[0] !== 1'b0) begin
         failures++;
         $display("FAIL irq unmasked: irq=%b required 0", irqv[0]);
      end
      bus_write(3'd2, 32'h01);
      checks++;
      if (irqv[0] !== 1'b1) begin
         failures++;
         $display("FAIL irq masked: irq=%b required 1", irqv[0]);
      end
      bus_write(3'd3, 32'h01);
      address = 3'd3;
      #1;
      checks++;
      if (irqv[0] !== 1'b0 || rd[0] !== 32'h0) begin
         failures++;
         $display("FAIL irq clear: irq=%b cap=%h required 0/0", irqv[0], rd[0]);
      end
      in_port = 8'hFD;
      repeat (S + 2) tick();
      in_port = 8'hFF;
      repeat (S + 2) tick();
      bus_write(3'd2, 32'h02);
      checks++;
      if (irqv[0] !== 1'b1) begin
         failures++;
         $display("FAIL irq bit1: irq=%b required 1", irqv[0]);
      end
      bus_write(3'd2, 32'h00);
      address = 3'd3;
      #1;
      checks++;
      if (irqv[0] !== 1'b0 || rd[0] !== 32'h2) begin
         failures++;
         $display("FAIL irq unmask: irq=%b cap=%h required 0/2", irqv[0], rd[0]);
      end
   endtask

   task automatic test_set_wins();
      in_port = 8'hFE;
      repeat (S + 3) tick();
      bus_write(3'd3, 32'hFF);
      bus_write(3'd2, 32'h01);
      address = 3'd3;
      #1;
      checks++;
      if (rd[0] !== 32'h0 || irqv[0] !== 1'b0) begin
         failures++;
         $display("FAIL set_wins pre: cap=%h irq=%b required 0/0", rd[0], irqv[0]);
      end
      in_port = 8'hFF;
      repeat (S) tick();
      bus_write(3'd3, 32'h01);
      address = 3'd3;
      #1;
      checks++;
      if (rd[0][0] !== 1'b1 || irqv[0] !== 1'b1) begin
         failures++;
         $display("FAIL set_wins: cap=%h irq=%b required bit0=1 irq=1", rd[0], irqv[0]);
      end
   endtask

   task automatic test_edge_types();
      in_port = 8'h7F;
      repeat (S + 3) tick();
      bus_write(3'd3, 32'hFF);
      in_port = 8'hFF;
      repeat (S + 2) tick();
      address = 3'd3;
      #1;
      checks++;
      if (rd[2][7] !== 1'b1 || rd[1][7] !== 1'b0 || rd[0][7] !== 1'b1) begin
         failures++;
         $display("FAIL edge rise: any=%h fall=%h rise=%h required b7 1/0/1", rd[2], rd[1], rd[0]);
      end
      bus_write(3'd3, 32'h80);
      address = 3'd3;
      #1;
      checks++;
      if (rd[2][7] !== 1'b0) begin
         failures++;
         $display("FAIL edge clear: any=%h required b7=0", rd[2]);
      end
      in_port = 8'h7F;
      repeat (S + 2) tick();
      address = 3'd3;
      #1;
      checks++;
      if (rd[2][7] !== 1'b1 || rd[1][7] !== 1'b1 || rd[0][7] !== 1'b0) begin
         failures++;
         $display("FAIL edge fall: any=%h fall=%h rise=%h required b7 1/1/0", rd[2], rd[1], rd[0]);
      end
   endtask

   task automatic test_async_reset();
      apply_reset(8'hFF);
      tick();
      reset_n = 1'b0;
      #1;
      checks++;
      if (outp[0] !== RV || oep[0] !== 8'h00 || irqv[0] !== 1'b0) begin
         failures++;
         $display("FAIL areset warm: out=%h oe=%h irq=%b", outp[0], oep[0], irqv[0]);
      end
      tick();
      reset_n = 1'b1;
      repeat (S + 4) tick();
      bus_write(3'd1, 32'hFF);
      bus_write(3'd2, 32'hFF);
      bus_write(3'd0, 32'h00);
      address    = 3'd0;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = 32'h55;
      #2;
      reset_n = 1'b0;
      #1;
      for (int e = 0; e < 3; e++) begin
         checks++;
         if (outp[e] !== RV || oep[e] !== 8'h00 || irqv[e] !== 1'b0) begin
            failures++;
            $display("FAIL areset write dut%0d: out=%h oe=%h irq=%b", e, outp[e], oep[e], irqv[e]);
         end
      end
      for (int a = 6; a < 8; a++) begin
         address = 3'(a);
         #1;
         checks++;
         if (rd[0] !== 32'h0 || rd[2] !== 32'h0) begin
            failures++;
            $display("FAIL areset read a=%0d: rd=%h/%h required 0", a, rd[0], rd[2]);
         end
      end
      bus_idle();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < S + 4; i++) begin
         tick();
         address = 3'd3;
         #1;
         checks++;
         if (rd[0] !== 32'h0 || rd[2] !== 32'h0) begin
            failures++;
            $display("FAIL areset rewarm cyc%0d: cap=%h/%h required 0", i, rd[0], rd[2]);
         end
      end
   endtask

   task automatic test_random();
      apply_reset(8'($urandom));
      for (int i = 0; i < 400; i++) begin
         for (int e = 0; e < 3; e++) begin
            checks++;
            if (outp[e] !== m_out || oep[e] !== m_dir || irqv[e] !== |(m_cap[e] & m_mask)) begin
               failures++;
               $display("FAIL random outs cyc%0d dut%0d: out=%h oe=%h irq=%b required %h %h %b",
                        i, e, outp[e], oep[e], irqv[e], m_out, m_dir, |(m_cap[e] & m_mask));
            end
         end
         in_port    = 8'($urandom);
         chipselect = 1'($urandom_range(0, 1));
         write_n    = 1'($urandom_range(0, 1));
         address    = 3'($urandom_range(0, 7));
         writedata  = $urandom;
         #1;
         for (int e = 0; e < 3; e++) begin
            checks++;
            if (rd[e] !== exp_rd(e, address)) begin
               failures++;
               $display("FAIL random read cyc%0d dut%0d a=%0d: rd=%h required %h",
                        i, e, address, rd[e], exp_rd(e, address));
            end
         end
         tick();
      end
      bus_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      in_port = '0;
      address = 3'd0;
      bus_idle();
      #3;
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      test_reset();
      test_data_path();
      test_warmup();
      test_irq();
      test_set_wins();
      test_edge_types();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
